// File: rtl/threshold_accelerator.sv
// Binarises a word-packed greyscale image in a single-port RAM: reads source words from the lower
// region, thresholds four pixels per word and writes the result word to the upper region.
module threshold_accelerator #(
   parameter int NUM_WORDS = 25344,
   parameter int OUT_BASE  = 25344
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  threshold,
   output logic        en,
   output logic        we,
   output logic [15:0] addr,
   output logic [31:0] dataW,
   input  logic [31:0] dataR,
   output logic        busy,
   output logic        finish,
   output logic [16:0] white_count
);

   if (NUM_WORDS < 1 || NUM_WORDS > 32768 || OUT_BASE < NUM_WORDS ||
       OUT_BASE + NUM_WORDS > 65536) begin : g_bad_params
      $error("threshold_accelerator: result region must follow the source region inside 64K words");
   end

   localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
   localparam logic [15:0] OUT_BASE_W = 16'(OUT_BASE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic [7:0]  thr_q, thr_d;
   logic [16:0] white_q, white_d;
   logic [3:0]  lane_hit;
   logic [31:0] bin_word;
   logic [2:0]  hit_count;

   // Pixel j lives in bits 8j+7:8j; a lane at or above the threshold becomes white.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi] = (dataR[8*gi +: 8] >= thr_q);
      assign bin_word[8*gi +: 8] = {8{lane_hit[gi]}};
   end

   assign hit_count = {2'b00, lane_hit[0]} + {2'b00, lane_hit[1]} +
                      {2'b00, lane_hit[2]} + {2'b00, lane_hit[3]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         thr_q   <= '0;
         white_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         thr_q   <= thr_d;
         white_q <= white_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      thr_d   = thr_q;
      white_d = white_q;
      en      = 1'b0;
      we      = 1'b0;
      addr    = '0;
      dataW   = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               thr_d   = threshold;
               idx_d   = '0;
               white_d = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            en      = 1'b1;
            addr    = idx_q;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            // dataR here is the registered result of the preceding READ cycle.
            en      = 1'b1;
            we      = 1'b1;
            addr    = OUT_BASE_W + idx_q;
            dataW   = bin_word;
            white_d = white_q + {14'd0, hit_count};
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 16'd1;
               state_d = S_READ;
            end
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q == S_READ) || (state_q == S_WRITE);
   assign finish      = (state_q == S_DONE);
   assign white_count = white_q;

endmodule
